fsm_moore_observer: RTL

Passive state observer for the 4-state, 2-bit-in/2-bit-out Moore controller. It samples the controller's input and output streams and reconstructs the controller's internal state from them, because states S0 and S3 both emit Y2 and cannot be read off the output directly. It sits beside the controller in the debug/verification fabric. It reports a candidate-state set, a lock indication with the estimated state and predicted output, and flags any output that no candidate state could have produced.

---
 rtl/fsm_moore_observer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fsm_moore_observer.sv
// Passive state observer for the 4-state Moore controller: tracks the set of states
// consistent with the sampled input/output streams and reports lock/estimate/mismatch.
module fsm_moore_observer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             obs_valid,
    input  logic [1:0]       obs_in,
    input  logic [1:0]       obs_out,
    output logic [3:0]       cand,
    output logic             locked,
    output logic [1:0]       est_state,
    output logic [1:0]       pred_out,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    typedef enum logic {StHunt, StLock} mode_e;

    mode_e            mode_q, mode_d;
    logic [3:0]       cand_q, cand_d;
    logic [1:0]       est_q, est_d;
    logic [1:0]       pred_q, pred_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       filt;
    logic [3:0]       succ;

    function automatic logic [1:0] next_state(input logic [1:0] s, input logic [1:0] in);
        logic [7:0] row;
        unique case (s)
            2'd0:    row = {2'd1, 2'd0, 2'd0, 2'd3};
            2'd1:    row = {2'd2, 2'd0, 2'd0, 2'd3};
            2'd2:    row = {2'd2, 2'd1, 2'd1, 2'd0};
            default: row = {2'd1, 2'd2, 2'd2, 2'd2};
        endcase
        return row[2*in +: 2];
    endfunction

    function automatic logic [1:0] state_out(input logic [1:0] s);
        unique case (s)
            2'd0:    return 2'b10;
            2'd1:    return 2'b01;
            2'd2:    return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    // States able to emit a given output; 11 is never legal.
    function automatic logic [3:0] out_mask(input logic [1:0] o);
        unique case (o)
            2'b10:   return 4'b1001;
            2'b01:   return 4'b0010;
            2'b00:   return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    always_comb begin
        filt = cand_q & out_mask(obs_out);
        succ = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (filt[i]) succ[next_state(2'(i), obs_in)] = 1'b1;
        end
    end

    always_comb begin
        mode_d = mode_q;
        cand_d = cand_q;
        est_d  = est_q;
        pred_d = pred_q;
        mis_d  = 1'b0;
        cnt_d  = cnt_q;
        if (clear) begin
            mode_d = StHunt;
            cand_d = 4'b1111;
            est_d  = 2'b00;
            pred_d = 2'b00;
        end else if (obs_valid) begin
            if (filt == 4'b0000) begin
                mode_d = StHunt;
                cand_d = 4'b1111;
                est_d  = 2'b00;
                pred_d = 2'b00;
                mis_d  = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cand_d = succ;
                if ($onehot(succ)) begin
                    mode_d = StLock;
                    est_d  = encode(succ);
                    pred_d = state_out(encode(succ));
                end else begin
                    mode_d = StHunt;
                    est_d  = 2'b00;
                    pred_d = 2'b00;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= StHunt;
            cand_q <= 4'b1111;
            est_q  <= 2'b00;
            pred_q <= 2'b00;
            mis_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            cand_q <= cand_d;
            est_q  <= est_d;
            pred_q <= pred_d;
            mis_q  <= mis_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cand         = cand_q;
    assign locked       = (mode_q == StLock);
    assign est_state    = est_q;
    assign pred_out     = pred_q;
    assign mismatch     = mis_q;
    assign mismatch_cnt = cnt_q;

endmodule
